// File: rtl/hello_scroll_pkg.sv
// Shared types and constants for the HELO scrolling display.
// Character codes, modes, FSM states and segment patterns.
package hello_scroll_pkg;

  typedef logic [2:0] char_t;

  localparam char_t CH_BLANK = 3'd0;
  localparam char_t CH_H     = 3'd1;
  localparam char_t CH_E     = 3'd2;
  localparam char_t CH_L     = 3'd3;
  localparam char_t CH_O     = 3'd4;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_BLINK = 2'b11
  } mode_t;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  // Vector bit 0 = seg a ... bit 6 = seg g, 0 = lit
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;

endpackage

// File: rtl/hello_scroll_display_seg7_char_lut.sv
// Character code to active-low 7-segment pattern.
// Ports: i_char (code), o_seg (bit 0 = a .. bit 6 = g).
module seg7_char_lut
  import hello_scroll_pkg::*;
(
  input  char_t      i_char,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (1'b1)
      (i_char == CH_H): o_seg = SEG_H;
      (i_char == CH_E): o_seg = SEG_E;
      (i_char == CH_L): o_seg = SEG_L;
      (i_char == CH_O): o_seg = SEG_O;
      default:          o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hello_scroll_display.sv
// Scrolling/blinking HELO message on NUM_DIGITS 7-seg digits.
// Ports: Clock, Resetn, Load, Msg, Mode, Enable -> Hex, Wrap.
module hello_scroll_display
  import hello_scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    Load,
  input  logic [3*MSG_LEN-1:0]    Msg,
  input  logic [1:0]              Mode,
  input  logic                    Enable,
  output logic [7*NUM_DIGITS-1:0] Hex,
  output logic                    Wrap
);

  localparam int PW = $clog2(MSG_LEN);
  localparam int CW = $clog2(TICK_DIV);

  char_t                   r_buf [MSG_LEN];
  logic [PW-1:0]           r_ptr;
  logic [CW-1:0]           r_cnt;
  logic                    r_phase;
  state_t                  r_state;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic                    r_wrap_d;
  logic                    r_wrap;

  mode_t                   w_mode;
  logic                    w_tick;
  logic                    w_wrap;
  logic [6:0]              w_seg [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] w_hex_nxt;

  assign w_mode = mode_t'(Mode);

  assign w_tick = (r_state == S_SHOW) && Enable &&
                  (r_cnt == CW'(TICK_DIV - 1));

  assign w_wrap = w_tick &&
    ((w_mode == MODE_LEFT  && r_ptr == PW'(MSG_LEN - 1)) ||
     (w_mode == MODE_RIGHT && r_ptr == '0));

  // Window index: one conditional subtract suffices since
  // ptr + offset < 2*MSG_LEN.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    localparam int OFF = NUM_DIGITS - 1 - g;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    assign w_sum = {1'b0, r_ptr} + (PW+1)'(OFF);
    assign w_idx = (w_sum >= (PW+1)'(MSG_LEN))
                 ? PW'(w_sum - (PW+1)'(MSG_LEN))
                 : w_sum[PW-1:0];

    seg7_char_lut u_lut (
      .i_char (r_buf[w_idx]),
      .o_seg  (w_seg[g])
    );
  end

  always_comb begin
    w_hex_nxt = '1;
    if (r_state == S_SHOW && !r_phase) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        w_hex_nxt[7*d +: 7] = w_seg[d];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_buf[i] <= CH_BLANK;
      end
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_state  <= S_BLANK;
      r_hex    <= '1;
      r_wrap_d <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_hex  <= w_hex_nxt;
      // Delayed so the pulse lines up with the Hex update
      r_wrap <= r_wrap_d;
      if (Load) begin
        for (int i = 0; i < MSG_LEN; i++) begin
          r_buf[i] <= Msg[3*i +: 3];
        end
        r_ptr    <= '0;
        r_cnt    <= '0;
        r_phase  <= 1'b0;
        r_wrap_d <= 1'b0;
        r_state  <= S_SHOW;
      end else begin
        r_wrap_d <= w_wrap;
        if (r_state == S_SHOW && Enable) begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
        if (w_mode != MODE_BLINK) begin
          r_phase <= 1'b0;
        end else if (w_tick) begin
          r_phase <= ~r_phase;
        end
        if (w_tick) begin
          unique case (w_mode)
            MODE_LEFT:
              r_ptr <= (r_ptr == PW'(MSG_LEN - 1))
                     ? '0 : r_ptr + 1'b1;
            MODE_RIGHT:
              r_ptr <= (r_ptr == '0)
                     ? PW'(MSG_LEN - 1) : r_ptr - 1'b1;
            MODE_HOLD, MODE_BLINK: ;
            default: ;
          endcase
        end
      end
    end
  end

  assign Hex  = r_hex;
  assign Wrap = r_wrap;

endmodule
